// File: rtl/regfile_pkg.sv
// Shared register-file constants used by decode, destination select and the register file.
// REGFILE_DBG_EN (build macro) enables the debug read port and write counter in regfile_32x32.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: $0 forced to zero, write-through bypass, else stored value.
// Instantiated once per operand port of regfile_32x32.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]            i_raddr,
    input  logic                         i_byp_en,
    input  logic [ADDR_W-1:0]            i_waddr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [NREG-1:0][DATA_W-1:0]  i_regs,
    output logic [DATA_W-1:0]            o_rdata
);

    logic w_zero;
    logic w_hit;

    assign w_zero = (i_raddr == ADDR_W'(REG_ZERO));

    // a hit needs a non-zero destination, so it never overlaps w_zero
    assign w_hit = i_byp_en
                && (i_waddr == i_raddr)
                && (i_waddr != ADDR_W'(REG_ZERO));

    always_comb begin
        o_rdata = '0;
        unique case (1'b1)
            w_zero:  o_rdata = '0;
            w_hit:   o_rdata = i_wdata;
            default: o_rdata = i_regs[i_raddr];
        endcase
    end

endmodule

// File: rtl/regfile_32x32.sv
// MIPS GPR file: 32 x 32, two bypassed read ports, one write port, $0 hardwired to zero.
// Define REGFILE_DBG_EN to add the raw debug read port (dbg_addr/dbg_data) and wr_count.
module regfile_32x32
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
`ifdef REGFILE_DBG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_count
`endif
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0]           r_regs [1:NREG-1];
    logic [NREG-1:0][DATA_W-1:0] w_regs;
    logic                        w_byp_en;
    logic                        w_commit;

    // reset wins over a same-cycle write, for both storage and bypass
    assign w_byp_en = we && !rst;
    assign w_commit = w_byp_en && (waddr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREG; i++) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (w_commit && (waddr == ADDR_W'(i))) begin
                r_regs[i] <= wdata;
            end
        end
    end

    always_comb begin
        w_regs = '0;
        for (int i = 1; i < NREG; i++) begin
            w_regs[i] = r_regs[i];
        end
    end

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_rd_a (
        .i_raddr  (raddr_a),
        .i_byp_en (w_byp_en),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_regs   (w_regs),
        .o_rdata  (rdata_a)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_rd_b (
        .i_raddr  (raddr_b),
        .i_byp_en (w_byp_en),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_regs   (w_regs),
        .o_rdata  (rdata_b)
    );

`ifdef REGFILE_DBG_EN
    logic [31:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign wr_count = r_wr_count;

    // raw stored value for the display path: deliberately no bypass
    assign dbg_data = (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : w_regs[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_32x32.sv
// Scoreboard bench for regfile_32x32: directed vectors, expectations queued, monitor compares.
// Build with REGFILE_DBG_EN to also exercise the debug port and write counter.
module tb_regfile_32x32;
    import regfile_pkg::*;

    localparam int P_A   = 0;
    localparam int P_B   = 1;
    localparam int P_DBG = 2;
    localparam int P_CNT = 3;

    typedef struct {
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wr_count;

    exp_t q [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_32x32 dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b)
`ifdef REGFILE_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
`endif
    );

`ifndef REGFILE_DBG_EN
    assign dbg_data = '0;
    assign wr_count = '0;
`endif

    function automatic void expect_v(int port, logic [31:0] v, string n);
        exp_t e;
        e.port = port;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endfunction

    task automatic drive(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                         logic [4:0] ra, logic [4:0] rb);
        rst     = r;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        raddr_a = ra;
        raddr_b = rb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: reads are combinational, so every queued entry is valid at the next negedge
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.port)
                    P_A:     act = rdata_a;
                    P_B:     act = rdata_b;
                    P_DBG:   act = dbg_data;
                    default: act = wr_count;
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s got %h want %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        dbg_addr = 5'd0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        step();

        // reset state
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        expect_v(P_A, 32'h0, "reset_a");
        expect_v(P_B, 32'h0, "reset_b");
        step();

        // 1: write then reset clears everything
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        expect_v(P_A, 32'hDEADBEEF, "t1_bypass");
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        expect_v(P_A, 32'hDEADBEEF, "t1_stored_pre_rst");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        expect_v(P_A, 32'h0, "t1_after_rst");
        step();
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
            expect_v(P_A, 32'h0, $sformatf("t1_clr_a_%0d", i));
            expect_v(P_B, 32'h0, $sformatf("t1_clr_b_%0d", 32 - i));
            step();
        end

        // 2: write $31 (bypass that cycle, stored next)
        drive(1'b0, 1'b1, REG_RA, 32'h00400010, 5'd0, REG_RA);
        expect_v(P_B, 32'h00400010, "t2_bypass");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, REG_RA);
        expect_v(P_B, 32'h00400010, "t2_stored");
        step();

        // 3: write to $0 dropped
        drive(1'b0, 1'b1, REG_ZERO, 32'hFFFFFFFF, REG_ZERO, 5'd0);
        expect_v(P_A, 32'h0, "t3_no_bypass");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, REG_ZERO, 5'd0);
        expect_v(P_A, 32'h0, "t3_no_store");
        step();

        // 4: both ports bypass the same register
        drive(1'b0, 1'b1, 5'd8, 32'h1, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        expect_v(P_A, 32'h1, "t4_old_a");
        step();
        drive(1'b0, 1'b1, 5'd8, 32'h2, 5'd8, 5'd8);
        expect_v(P_A, 32'h2, "t4_byp_a");
        expect_v(P_B, 32'h2, "t4_byp_b");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        expect_v(P_A, 32'h2, "t4_new_a");
        expect_v(P_B, 32'h2, "t4_new_b");
        step();

        // independent ports; we=0 must not bypass
        drive(1'b0, 1'b0, 5'd8, 32'h77, REG_RA, 5'd8);
        expect_v(P_A, 32'h00400010, "indep_a");
        expect_v(P_B, 32'h2, "indep_b_we0");
        step();

        // 5: reset discards a same-cycle write and its bypass
        drive(1'b1, 1'b1, 5'd9, 32'h55, 5'd9, 5'd9);
        expect_v(P_A, 32'h0, "t5_rst_cycle_a");
        expect_v(P_B, 32'h0, "t5_rst_cycle_b");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8);
        expect_v(P_A, 32'h0, "t5_after_9");
        expect_v(P_B, 32'h0, "t5_after_8");
        step();

`ifdef REGFILE_DBG_EN
        // 6: write counter and raw debug port
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_v(P_CNT, 32'd0, "t6_cnt_rst");
        step();
        drive(1'b0, 1'b1, 5'd3, 32'hA, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd3, 32'hB, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd3, 32'hC, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, REG_ZERO, 32'hE, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_v(P_CNT, 32'd3, "t6_cnt3");
        step();
        dbg_addr = 5'd3;
        drive(1'b0, 1'b1, 5'd3, 32'hD, 5'd3, 5'd0);
        expect_v(P_DBG, 32'hC, "t6_dbg_old");
        expect_v(P_A, 32'hD, "t6_a_byp");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_v(P_DBG, 32'hD, "t6_dbg_new");
        expect_v(P_CNT, 32'd4, "t6_cnt4");
        step();
        dbg_addr = REG_ZERO;
        expect_v(P_DBG, 32'h0, "t6_dbg_zero");
        step();
`endif

        step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
